// File: rtl/etapa_id_if.sv
`default_nettype none
// ============================================================================
//  Module   : etapa_id_if
//  Brief    : Fetch-control and decoded-instruction bus between the decode
//             stage (slave) and its environment (master).
//  Revision : 1.0  initial release
// ============================================================================
interface etapa_id_if #(
    parameter int COUNT_W = 6
);
    logic               start;
    logic [2:0]         algoritmo;
    logic [13:0]        instruccion;
    logic               sel_pc;
    logic [2:0]         sel_dir;
    logic               id_valid;
    logic [3:0]         id_opcode;
    logic [2:0]         id_rd;
    logic [2:0]         id_rs;
    logic [2:0]         id_rt;
    logic [7:0]         id_imm;
    logic               busy;
    logic               done;
    logic               error;
    logic [COUNT_W-1:0] instr_count;

    modport slave (
        input  start, algoritmo, instruccion,
        output sel_pc, sel_dir, id_valid, id_opcode, id_rd, id_rs, id_rt,
               id_imm, busy, done, error, instr_count
    );

    modport master (
        output start, algoritmo, instruccion,
        input  sel_pc, sel_dir, id_valid, id_opcode, id_rd, id_rs, id_rt,
               id_imm, busy, done, error, instr_count
    );
endinterface
`default_nettype wire

// File: rtl/etapa_id.sv
`default_nettype none
// ============================================================================
//  Module   : etapa_id
//  Brief    : Instruction decode stage. Parks the fetch PC on the selected
//             algorithm, drops the stale ROM word, then issues decoded
//             instructions until HALT or the instruction budget runs out.
//  Revision : 1.0  initial release
// ============================================================================
module etapa_id #(
    parameter logic [3:0] HALT_OPCODE = 4'hF,
    parameter int         MAX_INSTR   = 63,
    parameter int         COUNT_W     = 6
) (
    input  logic      clk,
    input  logic      reset,
    etapa_id_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    localparam logic [COUNT_W-1:0] c_max_count = COUNT_W'(MAX_INSTR);

    state_t             state_q, state_d;
    logic [2:0]         alg_q, alg_d;
    logic [13:0]        instr_q, instr_d;
    logic               id_valid_q, id_valid_d;
    logic               done_q, done_d;
    logic               error_q, error_d;
    logic [COUNT_W-1:0] count_q, count_d;
    logic               w_idle;

    assign w_idle = (state_q == ST_IDLE);

    always_comb begin
        state_d    = state_q;
        alg_d      = alg_q;
        instr_d    = instr_q;
        count_d    = count_q;
        id_valid_d = 1'b0;
        done_d     = 1'b0;
        error_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d = ST_FILL;
                    alg_d   = bus.algoritmo;
                    count_d = '0;
                end
            end
            // The word on the ROM bus here repeats the start-address word.
            ST_FILL: state_d = ST_RUN;
            ST_RUN: begin
                if (bus.instruccion[13:10] == HALT_OPCODE) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else if (count_q == c_max_count) begin
                    error_d = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    instr_d    = bus.instruccion;
                    id_valid_d = 1'b1;
                    count_d    = count_q + COUNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            alg_q      <= 3'd0;
            instr_q    <= 14'd0;
            id_valid_q <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            alg_q      <= alg_d;
            instr_q    <= instr_d;
            id_valid_q <= id_valid_d;
            done_q     <= done_d;
            error_q    <= error_d;
            count_q    <= count_d;
        end
    end

    // While idle the PC is reloaded from the live selector every cycle.
    assign bus.sel_pc      = w_idle;
    assign bus.sel_dir     = w_idle ? bus.algoritmo : alg_q;
    assign bus.busy        = !w_idle;
    assign bus.id_valid    = id_valid_q;
    assign bus.id_opcode   = instr_q[13:10];
    assign bus.id_rd       = instr_q[9:7];
    assign bus.id_rs       = instr_q[6:4];
    assign bus.id_rt       = instr_q[3:1];
    assign bus.id_imm      = instr_q[7:0];
    assign bus.done        = done_q;
    assign bus.error       = error_q;
    assign bus.instr_count = count_q;

endmodule
`default_nettype wire

// File: tb/tb_etapa_id.sv
`default_nettype none
// ============================================================================
//  Module   : tb_etapa_id
//  Brief    : Randomized scoreboard bench for etapa_id with a PC + sync-ROM
//             fetch model. Instruction budget is shrunk to 3.
//  Revision : 1.0  initial release
// ============================================================================
module tb_etapa_id;

    localparam int MAXI = 3;
    localparam logic [2:0] K_ISSUE = 3'b001;
    localparam logic [2:0] K_DONE  = 3'b010;
    localparam logic [2:0] K_ERR   = 3'b100;

    typedef struct {
        logic [2:0]  kind;
        logic [13:0] w;
        int          cyc;
    } ev_t;

    logic        clk;
    logic        reset;
    logic [7:0]  pc;
    logic [13:0] rom [256];
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    ev_t         exp_q[$];
    ev_t         mon_e;

    etapa_id_if #(.COUNT_W(6)) bus ();

    etapa_id #(
        .HALT_OPCODE(4'hF),
        .MAX_INSTR  (MAXI),
        .COUNT_W    (6)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Fetch stage: PC register feeding a synchronous ROM; algorithm k starts at k*32.
    always @(posedge clk) begin
        pc              <= bus.sel_pc ? {bus.sel_dir, 5'd0} : pc + 8'd1;
        bus.instruccion <= rom[pc];
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Monitor: every output event must match the head of the expected queue.
    always @(negedge clk) begin
        if (bus.id_valid || bus.done || bus.error) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_event", 32'({bus.error, bus.done, bus.id_valid}), 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("event_kind", 32'({bus.error, bus.done, bus.id_valid}), 32'(mon_e.kind));
                chk("event_cycle", 32'(cyc), 32'(mon_e.cyc));
                if (mon_e.kind == K_ISSUE) begin
                    chk("id_opcode", 32'(bus.id_opcode), 32'(mon_e.w[13:10]));
                    chk("id_rd",     32'(bus.id_rd),     32'(mon_e.w[9:7]));
                    chk("id_rs",     32'(bus.id_rs),     32'(mon_e.w[6:4]));
                    chk("id_rt",     32'(bus.id_rt),     32'(mon_e.w[3:1]));
                    chk("id_imm",    32'(bus.id_imm),    32'(mon_e.w[7:0]));
                end
            end
        end
    end

    task automatic run_prog(input int a, input int len, input bit has_halt,
                            input bit disturb, input bit mid_reset, input bit preset);
        int          base;
        int          issued;
        int          c0;
        logic [13:0] w;
        logic [13:0] last_w;
        ev_t         e;
        base   = a * 32;
        last_w = '0;
        if (!preset) begin
            for (int i = 0; i < 12; i++) begin
                w        = 14'($urandom);
                w[13:10] = 4'($urandom_range(0, 14));
                rom[base + i] = w;
            end
            if (has_halt) rom[base + len][13:10] = 4'hF;
        end
        @(negedge clk);
        bus.algoritmo = 3'(a);
        bus.start     = 1'b0;
        repeat (2) @(negedge clk);
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        c0        = cyc;
        bus.start = 1'b0;
        // Reference: walk the program from the start address.
        issued = 0;
        for (int k = 0; k < 12; k++) begin
            w     = rom[base + k];
            e.w   = w;
            e.cyc = c0 + 2 + k;
            if (w[13:10] == 4'hF) begin
                e.kind = K_DONE;
                exp_q.push_back(e);
                break;
            end
            if (issued == MAXI) begin
                e.kind = K_ERR;
                exp_q.push_back(e);
                break;
            end
            e.kind = K_ISSUE;
            exp_q.push_back(e);
            last_w = w;
            issued++;
        end
        if (mid_reset) begin
            while (exp_q.size() > 2) void'(exp_q.pop_back());
            repeat (4) @(negedge clk);
            reset = 1'b1;
            @(negedge clk);
            chk("rst_id_valid", 32'(bus.id_valid), 32'd0);
            chk("rst_sel_pc",   32'(bus.sel_pc),   32'd1);
            chk("rst_busy",     32'(bus.busy),     32'd0);
            chk("rst_count",    32'(bus.instr_count), 32'd0);
            chk("rst_pending",  32'(exp_q.size()), 32'd0);
            reset = 1'b0;
            exp_q.delete();
            return;
        end
        for (int t = 0; t < 60; t++) begin
            @(negedge clk);
            if (bus.busy) begin
                chk("run_sel_dir", 32'(bus.sel_dir), 32'(a));
                chk("run_sel_pc",  32'(bus.sel_pc),  32'd0);
                if (disturb) begin
                    bus.start     = 1'($urandom_range(0, 1));
                    bus.algoritmo = 3'd7;
                end
            end else begin
                bus.start = 1'b0;
                #1;
                if (exp_q.size() == 0) break;
            end
        end
        if (exp_q.size() != 0) begin
            chk("timeout_pending_events", 32'(exp_q.size()), 32'd0);
            exp_q.delete();
        end
        chk("end_count",  32'(bus.instr_count), 32'(issued));
        chk("end_busy",   32'(bus.busy),        32'd0);
        chk("end_sel_pc", 32'(bus.sel_pc),      32'd1);
        if (issued > 0) chk("hold_opcode", 32'(bus.id_opcode), 32'(last_w[13:10]));
    endtask

    initial begin
        for (int i = 0; i < 256; i++) rom[i] = 14'd0;
        reset         = 1'b1;
        bus.start     = 1'b0;
        bus.algoritmo = 3'd4;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("reset_sel_pc",   32'(bus.sel_pc),      32'd1);
        chk("reset_id_valid", 32'(bus.id_valid),    32'd0);
        chk("reset_busy",     32'(bus.busy),        32'd0);
        chk("reset_count",    32'(bus.instr_count), 32'd0);
        chk("reset_done",     32'({bus.error, bus.done}), 32'd0);
        chk("reset_sel_dir",  32'(bus.sel_dir),     32'd4);
        bus.algoritmo = 3'd6;
        #1;
        chk("idle_sel_dir_follows", 32'(bus.sel_dir), 32'd6);

        // Two instructions then HALT at algorithm 2.
        rom[64] = {4'h1, 10'h2A5};
        rom[65] = {4'h2, 10'h15A};
        rom[66] = {4'hF, 10'h000};
        run_prog(2, 2, 1'b1, 1'b0, 1'b0, 1'b1);
        run_prog(5, 0, 1'b1, 1'b0, 1'b0, 1'b0);   // HALT as the first word
        run_prog(1, 0, 1'b0, 1'b0, 1'b0, 1'b0);   // no HALT: budget abort
        run_prog(3, 5, 1'b1, 1'b0, 1'b1, 1'b0);   // reset mid-run
        run_prog(6, 2, 1'b1, 1'b1, 1'b0, 1'b0);   // start/algoritmo toggled in RUN
        for (int r = 0; r < 20; r++) begin
            run_prog(int'($urandom_range(0, 7)), int'($urandom_range(0, 5)),
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, 1'b0);
        end
        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "global timeout");
    end

endmodule
`default_nettype wire

// File: doc/etapa_id.md
# etapa_ID

Instruction decode stage paired with the fetch stage (`etapa_IF`). It owns the fetch stage's `sel_pc`/`sel_dir` controls. It parks the PC on the selected algorithm's start address while idle, releases it on `start`, and discards the one stale ROM word caused by the PC-register plus synchronous-ROM latency. It then registers and splits each valid 14-bit instruction for the execute stage until a HALT opcode or the instruction-budget watchdog ends the run.

## Interface
- `HALT_OPCODE`, 4'hF: opcode that terminates a run; it is never issued.
- `MAX_INSTR`, 63: maximum valid instructions issued per run. Must be ≤ 2^`COUNT_W`−1.
- `COUNT_W`, 6: width of `instr_count`.

- `clk`, in, 1: single clock; all state updates on the rising edge.
- `reset`, in, 1: synchronous, active-high.
- `start`, in, 1: run request; sampled only in IDLE.
- `algoritmo`, in, 3: algorithm select (0..7), forwarded as `sel_dir`.
- `instruccion`, in, 14: ROM output from the fetch stage.
- `sel_pc`, out, 1: 1 loads the algorithm address into the PC; 0 selects PC+1.
- `sel_dir`, out, 3: algorithm address select to the fetch stage.
- `id_valid`, out, 1: decoded fields below hold a valid instruction this cycle.
- `id_opcode`, out, 4: `instr[13:10]`.
- `id_rd`, out, 3: `instr[9:7]`.
- `id_rs`, out, 3: `instr[6:4]`.
- `id_rt`, out, 3: `instr[3:1]`.
- `id_imm`, out, 8: `instr[7:0]`.
- `busy`, out, 1: state is FILL or RUN.
- `done`, out, 1: one-cycle pulse after HALT is captured.
- `error`, out, 1: one-cycle pulse after a watchdog abort.
- `instr_count`, out, `COUNT_W`: valid instructions issued in the current or last run.

## Operation
- States are IDLE, FILL and RUN. Reset forces IDLE.
- Reset values are as follows:
  - all registered outputs are 0;
  - the latched algorithm `alg_q` is 0;
  - `sel_pc`=1;
  - `sel_dir`=`algoritmo`, since IDLE selects the input.
- In IDLE:
  - `sel_pc`=1 and `sel_dir`=`algoritmo` (combinational), so the PC is reloaded with the start address every cycle.
  - `start`=1 at an edge moves the state to FILL, latches `alg_q`<=`algoritmo`, and clears `instr_count`.
- In FILL and RUN:
  - `sel_pc`=0 and `sel_dir`=`alg_q`.
  - `start` and `algoritmo` are ignored.
- FILL lasts exactly one cycle and captures nothing; the ROM word present is a duplicate of the start-address word. The state then moves to RUN.
- At each RUN edge the current `instruccion` is evaluated:
  - If its opcode equals `HALT_OPCODE`: `id_valid`<=0, `done`<=1, go to IDLE.
  - Else if `instr_count`==`MAX_INSTR`: `id_valid`<=0, `error`<=1, go to IDLE.
  - Else: the decoded fields are loaded, `id_valid`<=1 and `instr_count` is incremented.
- The decoded fields hold their last value whenever `id_valid`=0. `instr_count` holds after a run ends.
- Reset in the middle of a run returns to IDLE on that edge. `id_valid`, `done` and `error` are 0 on the following cycle; any in-flight instruction is dropped.
- Precondition: `algoritmo` must be stable for at least 2 cycles before the `start` edge, so that the parked PC and the ROM output both reflect it.

## Timing
- Let E0 be the edge at which `start` is accepted.
  - After E1, the state is RUN.
  - The word at the start address `D` is captured at E2, so `id_valid`=1 from E2 to E3.
  - The word at `D+1` is issued after E3, and so on.
  - Start-to-first-valid latency is 2 cycles after E0; throughput is then 1 instruction per cycle.
- `done` and `error` are high for exactly the one cycle following the terminating edge. `sel_pc`=1 in that same cycle.
- `busy` is combinational from the state and deasserts in the cycle in which `done` or `error` is high.

## Test plan
- Reset with `start`=0 → `sel_pc`=1, `id_valid`=0, `busy`=0, `instr_count`=0. `sel_dir` follows `algoritmo` 3'd4 → 4.
- `algoritmo`=2 held 2 cycles, then `start` pulse, with ROM words at D..D+2 = {4'h1,…}, {4'h2,…}, {4'hF,…}:
  - `id_valid` is high for 2 consecutive cycles beginning 2 cycles after E0, with opcodes 1 then 2;
  - `done` pulses on the next cycle;
  - `instr_count`=2 at the end.
- HALT as the first word (at D) → `id_valid` never asserts, `done` pulses 2 cycles after E0, `instr_count`=0.
- Set `MAX_INSTR`=3 with no HALT within 10 words → exactly 3 valid issues, then an `error` pulse, a return to IDLE, and `instr_count`=3.
- Reset asserted in the cycle after the first `id_valid` → on the next cycle state is IDLE, `id_valid`=0, `sel_pc`=1.
- In RUN, `start`=1 and `algoritmo`=7 → no effect: `sel_dir` stays at the latched value and the issue sequence is unchanged.
